// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with ASCII '0'..'3' mode-command decode
//
// Purpose: deserialises 8N1 frames on RxD using 16x oversampling. Each bit is
// taken as the 2-of-3 majority of samples on ticks 7, 8 and 9. Good bytes are
// strobed out on valid. The bytes '0'..'3' also update a 2-bit opcode one clock
// later.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   RxD          in   serial line, idle high, asynchronous to clk
//   data         out  [7:0] last good byte, LSB first on the wire
//   valid        out  one-cycle pulse when data is updated
//   frame_err    out  one-cycle pulse when the stop bit is sampled low
//   opcode       out  [1:0] last decoded mode command
//   opcode_valid out  one-cycle pulse when opcode is updated

module uart_cmd_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic [1:0] opcode,
  output logic       opcode_valid
);

  // Rounded divide of clk down to the oversample tick rate, never below 1.
  localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_rx_s;
  logic [DW-1:0] r_div_cnt;
  logic [3:0]  r_t;
  logic [2:0]  r_idx;
  logic        r_s7;
  logic        r_s8;
  logic        r_bit;
  logic [7:0]  r_shift;

  logic        w_tick;
  logic        w_maj;

  assign w_tick = (r_div_cnt == DW'(DIV - 1));
  // Only meaningful on tick 9, when r_s7/r_s8 hold the earlier two samples.
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_t          <= '0;
      r_idx        <= '0;
      r_s7         <= 1'b1;
      r_s8         <= 1'b1;
      r_bit        <= 1'b1;
      r_shift      <= '0;
      data         <= '0;
      valid        <= 1'b0;
      frame_err    <= 1'b0;
      opcode       <= '0;
      opcode_valid <= 1'b0;
    end else begin
      r_sync1      <= RxD;
      r_rx_s       <= r_sync1;
      valid        <= 1'b0;
      frame_err    <= 1'b0;
      opcode_valid <= 1'b0;

      // data and valid are already registered, so the decode lands one clock after valid.
      if (valid && (data[7:2] == 6'b001100)) begin
        opcode       <= data[1:0];
        opcode_valid <= 1'b1;
      end

      // Holding the divider at zero while idle aligns ticks to the start edge.
      if (r_state == S_IDLE || w_tick) r_div_cnt <= '0;
      else                             r_div_cnt <= r_div_cnt + DW'(1);

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_t     <= '0;
          end
        end

        S_START, S_DATA, S_STOP: begin
          if (w_tick) begin
            r_t <= r_t + 4'd1;
            if (r_t == 4'd7) r_s7  <= r_rx_s;
            if (r_t == 4'd8) r_s8  <= r_rx_s;
            if (r_t == 4'd9) r_bit <= w_maj;

            // The stop decision comes early, at tick 9, so a back-to-back
            // start edge that begins where this bit ends is not missed.
            if (r_state == S_STOP && r_t == 4'd9) begin
              if (w_maj) begin
                data    <= r_shift;
                valid   <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= S_BRK;
              end
            end

            if (r_t == 4'd15) begin
              if (r_state == S_START) begin
                if (r_bit) r_state <= S_IDLE;
                else begin
                  r_state <= S_DATA;
                  r_idx   <= '0;
                end
              end else if (r_state == S_DATA) begin
                r_shift <= {r_bit, r_shift[7:1]};
                r_idx   <= r_idx + 3'd1;
                if (r_idx == 3'd7) r_state <= S_STOP;
              end
            end
          end
        end

        S_BRK: begin
          if (r_rx_s) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - scoreboard bench for uart_cmd_rx with a frame-level reference model

module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic [1:0] opcode;
  logic       opcode_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_data[$];
  logic [1:0] exp_op[$];
  int         exp_ferr = 0;
  logic [7:0] m_data = 8'h00;
  logic [1:0] m_op   = 2'b00;

  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .RxD(RxD),
    .data(data), .valid(valid), .frame_err(frame_err),
    .opcode(opcode), .opcode_valid(opcode_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference model at frame level: a good frame delivers its byte, and an
  // ASCII digit '0'..'3' selects that mode; a bad stop bit yields only an error.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      exp_data.push_back(b);
      m_data = b;
      if (b >= 8'h30 && b <= 8'h33) begin
        m_op = 2'(b - 8'h30);
        exp_op.push_back(m_op);
      end
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic drive(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_lvl);
    model_frame(b, stop_lvl);
    drive(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive(b[i], bclk);
    drive(stop_lvl, bclk);
    RxD = 1'b1;
  endtask

  // Called once the line has been idle past a frame: all expected pulses must have appeared.
  task automatic settle(input string name);
    repeat (4) @(negedge clk);
    chk({name, "_drain"}, exp_data.size() + exp_op.size() + exp_ferr, 0);
    chk({name, "_data"}, data, m_data);
    chk({name, "_opcode"}, opcode, m_op);
  endtask

  // Monitor: pops expectations whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && frame_err) chk("valid_and_ferr", 1, 0);
      if (valid) begin
        if (exp_data.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("rx_byte", data, exp_data.pop_front());
      end
      if (frame_err) begin
        if (exp_ferr == 0) chk("unexpected_frame_err", 1, 0);
        else begin
          exp_ferr--;
          chk("frame_err_seen", 1, 1 - (valid ? 1 : 0));
        end
      end
      if (opcode_valid) begin
        if (exp_op.size() == 0) chk("unexpected_opcode_valid", 1, 0);
        else chk("opcode_update", opcode, exp_op.pop_front());
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         per;

    rst_n = 1'b0;
    RxD   = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data", data, 0);
    chk("reset_valid", valid, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_opcode", opcode, 0);
    chk("reset_opv", opcode_valid, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Back-to-back frames, one stop bit each.
    send_byte(8'h55, BIT_CLKS, 1'b1);
    send_byte(8'hA3, BIT_CLKS, 1'b1);
    settle("b2b");

    // Opcode decode, then a non-command byte leaves opcode alone.
    send_byte(8'h32, BIT_CLKS, 1'b1);
    settle("op2");
    send_byte(8'h78, BIT_CLKS, 1'b1);
    settle("op_x");

    // Short low glitch is rejected as a false start.
    drive(1'b0, 40);
    drive(1'b1, 200);
    settle("glitch");
    send_byte(8'h31, BIT_CLKS, 1'b1);
    settle("op1");

    // Low stop bit plus held break, then recovery.
    send_byte(8'h33, BIT_CLKS, 1'b0);
    RxD = 1'b0;
    drive(1'b0, 3 * BIT_CLKS);
    drive(1'b1, BIT_CLKS);
    settle("break");
    send_byte(8'h30, BIT_CLKS, 1'b1);
    settle("op0");

    // +/-3% baud mismatch.
    send_byte(8'hC6, 155, 1'b1);
    settle("fast");
    send_byte(8'hC6, 165, 1'b1);
    settle("slow");

    // Randomized frames: random bytes (biased toward commands), baud and gaps.
    for (int k = 0; k < 12; k++) begin
      rb  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 8'h30 + 8'($urandom_range(0, 3));
      per = $urandom_range(155, 165);
      send_byte(rb, per, 1'b1);
      drive(1'b1, $urandom_range(0, 200));
    end
    settle("random");

    // Reset asserted during data bit 4 of a frame.
    send_byte(8'h33, BIT_CLKS, 1'b1);
    settle("pre_reset");
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(1'(8'h31 >> i), BIT_CLKS);
    drive(1'b1, BIT_CLKS / 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_data", data, 0);
    chk("async_rst_opcode", opcode, 0);
    chk("async_rst_valid", valid, 0);
    chk("async_rst_ferr", frame_err, 0);
    m_data = 8'h00;
    m_op   = 2'b00;
    RxD    = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h31, BIT_CLKS, 1'b1);
    settle("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
